spi_byte_shifter: RTL and testbench

SPI byte engine driving the PmodCLS serial link, directly downstream of the display/clear sequencing FSM. It accepts one byte per `begin_transmission` pulse and shifts it out MSB-first in SPI mode 0, capturing MISO in parallel. It returns a one-cycle `end_transmission` pulse that advances the upstream FSM to its next byte. Slave select is owned by the upstream FSM and is only passed through to the pin.

---
 rtl/spi_byte_shifter.sv | 152 +++++++++++++++
 tb/tb_spi_byte_shifter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - SPI mode-0 byte engine for the PmodCLS link
//
// Shifts one byte out MSB-first per begin_transmission pulse while capturing
// MISO, then returns a single-cycle end_transmission pulse.
//
// Parameters
//   CLK_DIV            clk cycles per SCLK half-period (1..255)
//
// Ports
//   clk                system clock, all state on its rising edge
//   rst                synchronous active-high reset
//   send_data[7:0]     byte to transmit, sampled on an accepted begin
//   begin_transmission start request, one-cycle pulse from the upstream FSM
//   slave_select       active-low chip select from the upstream FSM
//   miso               serial data from the slave
//   end_transmission   one-cycle pulse: byte done, received_data valid
//   received_data[7:0] last byte captured from miso, MSB first
//   sclk               SPI clock, idles low
//   mosi               serial data to the slave
//   ss                 combinational copy of slave_select

module spi_byte_shifter #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] send_data,
    input  logic       begin_transmission,
    input  logic       slave_select,
    input  logic       miso,
    output logic       end_transmission,
    output logic [7:0] received_data,
    output logic       sclk,
    output logic       mosi,
    output logic       ss
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Terminal count of the half-period divider.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       end_q, end_d;
    logic [7:0] recv_q, recv_d;

    // Chip select belongs to the upstream FSM; it is never gated by reset.
    assign ss               = slave_select;
    assign sclk             = sclk_q;
    assign mosi             = mosi_q;
    assign end_transmission = end_q;
    assign received_data    = recv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= 8'd0;
            bit_q   <= 3'd0;
            tx_q    <= 8'd0;
            rx_q    <= 8'd0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            end_q   <= 1'b0;
            recv_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            end_q   <= end_d;
            recv_q  <= recv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        end_d   = 1'b0;
        recv_d  = recv_q;

        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                if (begin_transmission) begin
                    // MSB goes on the wire now, a full half-period before
                    // the first rising edge.
                    tx_d    = send_data;
                    mosi_d  = send_data[7];
                    div_d   = 8'd0;
                    bit_d   = 3'd0;
                    rx_d    = 8'd0;
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                if (div_q == DIV_LAST) begin
                    div_d  = 8'd0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: slave data is sampled here.
                        rx_d = {rx_q[6:0], miso};
                    end else if (bit_q == 3'd7) begin
                        // Falling edge of the last bit ends the byte.
                        state_d = ST_DONE;
                    end else begin
                        // Falling edge: present the next bit for a full
                        // half-period of setup before the next rise.
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                        bit_d  = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            ST_DONE: begin
                end_d   = 1'b1;
                recv_d  = rx_q;
                mosi_d  = 1'b0;
                sclk_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_byte_shifter.sv
// tb/tb_spi_byte_shifter.sv - self-checking bench for spi_byte_shifter

module tb_spi_byte_shifter;

    typedef struct packed {
        logic [7:0]  rx;
        logic [7:0]  tx;
        logic [31:0] due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic       rst;
    logic [7:0] send_data4, send_data1;
    logic       begin4, begin1;
    logic       ss_in4, ss_in1;
    logic       loop4;
    logic       miso4, miso1;
    logic       end4, end1, sclk4, sclk1, mosi4, mosi1, ss4, ss1;
    logic [7:0] rx4, rx1;

    assign miso4 = loop4 ? mosi4 : 1'b0;
    assign miso1 = 1'b1;

    spi_byte_shifter #(.CLK_DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .send_data(send_data4),
        .begin_transmission(begin4), .slave_select(ss_in4), .miso(miso4),
        .end_transmission(end4), .received_data(rx4),
        .sclk(sclk4), .mosi(mosi4), .ss(ss4)
    );

    spi_byte_shifter #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .send_data(send_data1),
        .begin_transmission(begin1), .slave_select(ss_in1), .miso(miso1),
        .end_transmission(end1), .received_data(rx1),
        .sclk(sclk1), .mosi(mosi1), .ss(ss1)
    );

    exp_t q4[$];
    exp_t q1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor for the CLK_DIV=4 instance: records mosi on each SCLK rise and
    // checks every end pulse against the scoreboard head.
    logic       prev_sclk4 = 1'b0;
    int         rises4 = 0;
    logic [7:0] bits4 = 8'd0;
    always @(negedge clk) begin
        chk("ss4_follow", ss4, ss_in4);
        if (rst) begin
            rises4     <= 0;
            bits4      <= 8'd0;
            prev_sclk4 <= 1'b0;
        end else begin
            prev_sclk4 <= sclk4;
            if (sclk4 && !prev_sclk4) begin
                rises4 <= rises4 + 1;
                bits4  <= {bits4[6:0], mosi4};
            end
            if (end4) begin
                if (q4.size() == 0) begin
                    chk("end4_unexpected", end4, 1'b0);
                end else begin
                    chk("end4_rx", rx4, q4[0].rx);
                    chk("end4_cycle", cyc, q4[0].due);
                    chk("end4_sclk_pulses", rises4, 8);
                    chk("end4_mosi_bits", bits4, q4[0].tx);
                    chk("end4_sclk_low", sclk4, 1'b0);
                    chk("end4_mosi_low", mosi4, 1'b0);
                    void'(q4.pop_front());
                end
                rises4 <= 0;
                bits4  <= 8'd0;
            end
        end
    end

    logic       prev_sclk1 = 1'b0;
    int         rises1 = 0;
    logic [7:0] bits1 = 8'd0;
    always @(negedge clk) begin
        chk("ss1_follow", ss1, ss_in1);
        if (rst) begin
            rises1     <= 0;
            bits1      <= 8'd0;
            prev_sclk1 <= 1'b0;
        end else begin
            prev_sclk1 <= sclk1;
            if (sclk1 && !prev_sclk1) begin
                rises1 <= rises1 + 1;
                bits1  <= {bits1[6:0], mosi1};
            end
            if (end1) begin
                if (q1.size() == 0) begin
                    chk("end1_unexpected", end1, 1'b0);
                end else begin
                    chk("end1_rx", rx1, q1[0].rx);
                    chk("end1_cycle", cyc, q1[0].due);
                    chk("end1_sclk_pulses", rises1, 8);
                    chk("end1_mosi_bits", bits1, q1[0].tx);
                    void'(q1.pop_front());
                end
                rises1 <= 0;
                bits1  <= 8'd0;
            end
        end
    end

    // Called right after a negedge; begin is sampled at the next posedge and
    // the end pulse is seen at the negedge 16*CLK_DIV+2 cycles from now.
    task automatic send4(input logic [7:0] d, input logic [7:0] rx_exp);
        send_data4 = d;
        begin4     = 1'b1;
        q4.push_back(exp_t'{rx: rx_exp, tx: d, due: 32'(cyc + 16 * 4 + 2)});
        @(negedge clk);
        begin4 = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d, input logic [7:0] rx_exp);
        send_data1 = d;
        begin1     = 1'b1;
        q1.push_back(exp_t'{rx: rx_exp, tx: d, due: 32'(cyc + 16 * 1 + 2)});
        @(negedge clk);
        begin1 = 1'b0;
    endtask

    task automatic drain4(input int budget);
        int n = 0;
        while (q4.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain4_pending", q4.size(), 0);
        q4.delete();
    endtask

    task automatic drain1(input int budget);
        int n = 0;
        while (q1.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain1_pending", q1.size(), 0);
        q1.delete();
    endtask

    task automatic wait_end4(input int budget);
        int n = 0;
        while (!end4 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("end4_seen", end4, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        begin4     = 1'b0;
        begin1     = 1'b0;
        send_data4 = 8'h00;
        send_data1 = 8'h00;
        ss_in4     = 1'b1;
        ss_in1     = 1'b1;
        loop4      = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_sclk4", sclk4, 1'b0);
        chk("rst_mosi4", mosi4, 1'b0);
        chk("rst_end4", end4, 1'b0);
        chk("rst_rx4", rx4, 8'h00);
        chk("rst_sclk1", sclk1, 1'b0);
        chk("rst_rx1", rx1, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Loopback 8'hA5 at CLK_DIV=4.
        ss_in4 = 1'b0;
        send4(8'hA5, 8'hA5);
        drain4(200);
        chk("a5_rx_hold", rx4, 8'hA5);
        ss_in4 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset for two cycles in the middle of an 8'hFF transfer.
        send_data4 = 8'hFF;
        begin4     = 1'b1;
        @(negedge clk);
        begin4 = 1'b0;
        repeat (20) @(negedge clk);
        chk("midxfer_mosi_high", mosi4, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sclk4", sclk4, 1'b0);
        chk("midrst_mosi4", mosi4, 1'b0);
        chk("midrst_end4", end4, 1'b0);
        chk("midrst_rx4", rx4, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_sclk4", sclk4, 1'b0);
        chk("postrst_mosi4", mosi4, 1'b0);
        repeat (100) @(negedge clk);
        chk("postrst_rx4", rx4, 8'h00);

        // CLK_DIV=1, miso held high, all-zero byte.
        send1(8'h00, 8'hFF);
        drain1(60);
        chk("div1_rx", rx1, 8'hFF);

        // A begin during XFER must be ignored.
        send4(8'h3C, 8'h3C);
        repeat (9) @(negedge clk);
        send_data4 = 8'hC3;
        begin4     = 1'b1;
        @(negedge clk);
        begin4     = 1'b0;
        send_data4 = 8'h00;
        drain4(200);
        repeat (80) @(negedge clk);
        chk("busy_rx", rx4, 8'h3C);

        // Back-to-back bytes, begin re-asserted in the end-pulse cycle;
        // slave_select rises mid-byte without disturbing the transfer.
        ss_in4 = 1'b0;
        send4(8'h7C, 8'h7C);
        wait_end4(300);
        send4(8'h1B, 8'h1B);
        repeat (20) @(negedge clk);
        ss_in4 = 1'b1;
        wait_end4(300);
        ss_in4 = 1'b0;
        send4(8'h5B, 8'h5B);
        drain4(300);
        chk("b2b_last_rx", rx4, 8'h5B);
        ss_in4 = 1'b1;

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
